// File: rtl/global_ctrl_seq_if.sv
// Control bundle for global_ctrl_seq. keepalive and wdt_fired exist only when
// GLOBAL_CTRL_SEQ_WATCHDOG_EN is defined.
interface global_ctrl_seq_if #(
    parameter int N = 4
);
    logic         start;
    logic         stop;
    logic [N-1:0] out;
    logic         all_on;
    logic         busy;
`ifdef GLOBAL_CTRL_SEQ_WATCHDOG_EN
    logic         keepalive;
    logic         wdt_fired;

    modport master (output start, stop, keepalive, input out, all_on, busy, wdt_fired);
    modport slave  (input start, stop, keepalive, output out, all_on, busy, wdt_fired);
`else
    modport master (output start, stop, input out, all_on, busy);
    modport slave  (input start, stop, output out, all_on, busy);
`endif
endinterface

// File: rtl/global_ctrl_seq.sv
// Staggered, registered enable lines for global buffers (thermometer ramp up/down).
// Optional watchdog enabled with `define GLOBAL_CTRL_SEQ_WATCHDOG_EN.
module global_ctrl_seq #(
    parameter int N           = 4,
    parameter int STAGGER     = 16,
    parameter int SYNC_STAGES = 2
`ifdef GLOBAL_CTRL_SEQ_WATCHDOG_EN
   ,parameter int WDT_CYCLES  = 1024
`endif
) (
    input  logic             CLK,
    input  logic             rst_n,
    global_ctrl_seq_if.slave ctrl
);
    localparam int IDX_W = $clog2(N + 1);
    localparam int TMR_W = $clog2(STAGGER + 1);

    localparam logic [2:0] S_SYNC      = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_RAMP_UP   = 3'd2;
    localparam logic [2:0] S_ON        = 3'd3;
    localparam logic [2:0] S_RAMP_DOWN = 3'd4;

    localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]       IDX_ONE    = IDX_W'(1);
    localparam logic [TMR_W-1:0]       TMR_RELOAD = TMR_W'(STAGGER - 1);
    localparam logic [N-1:0]           OUT_LSB    = N'(1);
    localparam logic [SYNC_STAGES-2:0] SYNC_LSB   = (SYNC_STAGES - 1)'(1);

    logic [2:0]             r_state;
    logic [SYNC_STAGES-2:0] r_sync;
    logic [IDX_W-1:0]       r_idx;
    logic [TMR_W-1:0]       r_tmr;
    logic [N-1:0]           r_out;
    logic                   r_all_on;
    logic                   r_busy;

    logic [2:0]             w_state_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [TMR_W-1:0]       w_tmr_nxt;
    logic [N-1:0]           w_out_nxt;
    logic                   w_stop;

`ifdef GLOBAL_CTRL_SEQ_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_RELOAD = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] r_wdt;
    logic             r_fired;
    logic             w_timeout;

    assign w_timeout = (r_state == S_ON) && (r_wdt == '0) && !ctrl.keepalive;
    assign w_stop    = ctrl.stop | w_timeout;
`else
    assign w_stop    = ctrl.stop;
`endif

    // out is a thermometer code, so setting out[idx] is a shift-in of a one
    // and clearing out[idx-1] is a shift-out from the top.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tmr_nxt   = r_tmr;
        w_out_nxt   = r_out;
        case (r_state)
            S_SYNC: begin
                if (r_sync[SYNC_STAGES-2])
                    w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (ctrl.start && !w_stop) begin
                    w_state_nxt = S_RAMP_UP;
                    w_tmr_nxt   = '0;
                end
            end
            S_RAMP_UP: begin
                if (w_stop) begin
                    w_state_nxt = S_RAMP_DOWN;
                    w_tmr_nxt   = '0;
                end else if (r_tmr == '0) begin
                    w_out_nxt = (r_out << 1) | OUT_LSB;
                    w_idx_nxt = r_idx + 1'b1;
                    w_tmr_nxt = TMR_RELOAD;
                    if (r_idx == IDX_LAST)
                        w_state_nxt = S_ON;
                end else begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end
            end
            S_ON: begin
                if (w_stop) begin
                    w_state_nxt = S_RAMP_DOWN;
                    w_tmr_nxt   = '0;
                end
            end
            S_RAMP_DOWN: begin
                if (r_idx == '0) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tmr == '0) begin
                    w_out_nxt = r_out >> 1;
                    w_idx_nxt = r_idx - 1'b1;
                    w_tmr_nxt = TMR_RELOAD;
                    if (r_idx == IDX_ONE)
                        w_state_nxt = S_IDLE;
                end else begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end
            end
            default: w_state_nxt = S_SYNC;
        endcase
    end

    // The state register leaving SYNC acts as the last synchronizer stage.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_SYNC;
            r_sync   <= '0;
            r_idx    <= '0;
            r_tmr    <= '0;
            r_out    <= '0;
            r_all_on <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_sync   <= (r_sync << 1) | SYNC_LSB;
            r_idx    <= w_idx_nxt;
            r_tmr    <= w_tmr_nxt;
            r_out    <= w_out_nxt;
            r_all_on <= (w_state_nxt == S_ON);
            r_busy   <= (w_state_nxt == S_SYNC) || (w_state_nxt == S_RAMP_UP) ||
                        (w_state_nxt == S_RAMP_DOWN);
        end
    end

`ifdef GLOBAL_CTRL_SEQ_WATCHDOG_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt   <= '0;
            r_fired <= 1'b0;
        end else begin
            if (r_state != S_ON && w_state_nxt == S_ON)
                r_wdt <= WDT_RELOAD;
            else if (r_state == S_ON && ctrl.keepalive)
                r_wdt <= WDT_RELOAD;
            else if (r_state == S_ON && r_wdt != '0)
                r_wdt <= r_wdt - 1'b1;

            if (w_timeout)
                r_fired <= 1'b1;
            else if (r_state == S_IDLE && ctrl.start && !w_stop)
                r_fired <= 1'b0;
        end
    end

    assign ctrl.wdt_fired = r_fired;
`endif

    assign ctrl.out    = r_out;
    assign ctrl.all_on = r_all_on;
    assign ctrl.busy   = r_busy;
endmodule

// File: tb/tb_global_ctrl_seq.sv
// Scoreboard bench for global_ctrl_seq: a time-based reference model queues the
// expected outputs for each clock edge and a monitor compares them after the edge.
module tb_global_ctrl_seq;
    localparam int N           = 4;
    localparam int STAGGER     = 16;
    localparam int SYNC_STAGES = 2;
    localparam int WDT         = 8;
`ifdef GLOBAL_CTRL_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    typedef enum {MSync, MIdle, MUp, MOn, MDown} modelMode_e;
    typedef struct {
        logic [N-1:0] out;
        logic         allOn;
        logic         busy;
        logic         fired;
    } expect_t;

    logic       CLK = 1'b0;
    logic       rstN = 1'b1;
    int         checks = 0;
    int         errors = 0;
    bit         sbActive = 1'b0;
    expect_t    sbQueue[$];

    modelMode_e mMode = MSync;
    int         mLines = 0;
    int         mSyncCnt = 0;
    int         mCyc = 0;
    int         mNextAt = 0;
    int         mDeadline = 0;
    bit         mFired = 1'b0;

    global_ctrl_seq_if #(.N(N)) bus();

`ifdef GLOBAL_CTRL_SEQ_WATCHDOG_EN
    global_ctrl_seq #(.N(N), .STAGGER(STAGGER), .SYNC_STAGES(SYNC_STAGES), .WDT_CYCLES(WDT)) dut (
        .CLK(CLK), .rst_n(rstN), .ctrl(bus));
`else
    global_ctrl_seq #(.N(N), .STAGGER(STAGGER), .SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK(CLK), .rst_n(rstN), .ctrl(bus));
`endif

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, mCyc);
        end
    endtask

    task automatic modelReset();
        mMode    = MSync;
        mLines   = 0;
        mSyncCnt = 0;
        mFired   = 1'b0;
    endtask

    // Lines change at absolute cycle times; the watchdog is an absolute deadline.
    task automatic modelEdge(input bit rstn, input bit st, input bit sp, input bit ka);
        bit effStop;
        mCyc++;
        if (!rstn) begin
            modelReset();
            return;
        end
        effStop = sp;
        if (WD_EN && mMode == MOn && !ka && mCyc == mDeadline) begin
            effStop = 1'b1;
            mFired  = 1'b1;
        end
        if (mMode == MOn && ka)
            mDeadline = mCyc + WDT;
        case (mMode)
            MSync: begin
                mSyncCnt++;
                if (mSyncCnt >= SYNC_STAGES) mMode = MIdle;
            end
            MIdle: if (st && !sp) begin
                mMode   = MUp;
                mNextAt = mCyc + 1;
                mFired  = 1'b0;
            end
            MUp: begin
                if (sp) begin
                    mMode   = MDown;
                    mNextAt = mCyc + 1;
                end else if (mCyc == mNextAt) begin
                    mLines++;
                    mNextAt += STAGGER;
                    if (mLines == N) begin
                        mMode     = MOn;
                        mDeadline = mCyc + WDT;
                    end
                end
            end
            MOn: if (effStop) begin
                mMode   = MDown;
                mNextAt = mCyc + 1;
            end
            MDown: if (mCyc == mNextAt) begin
                if (mLines > 0) mLines--;
                mNextAt += STAGGER;
                if (mLines == 0) mMode = MIdle;
            end
            default: mMode = MSync;
        endcase
    endtask

    function automatic expect_t modelView();
        expect_t e;
        e.out   = N'((32'd1 << mLines) - 1);
        e.allOn = (mMode == MOn);
        e.busy  = (mMode == MSync) || (mMode == MUp) || (mMode == MDown);
        e.fired = mFired;
        return e;
    endfunction

    task automatic applyStimulus(input bit st, input bit sp, input bit ka, input bit rstn);
        @(negedge CLK);
        bus.start = st;
        bus.stop  = sp;
`ifdef GLOBAL_CTRL_SEQ_WATCHDOG_EN
        bus.keepalive = ka;
`endif
        rstN = rstn;
        modelEdge(rstn, st, sp, ka);
        sbQueue.push_back(modelView());
        sbActive = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Drops rst_n between clock edges and checks the outputs clear with no edge.
    task automatic asyncResetCheck();
        expect_t e;
        @(negedge CLK);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        #2;
        rstN = 1'b0;
        modelReset();
        e = modelView();
        #1;
        checkOutput("async_rst_out", 32'(bus.out), 32'(e.out));
        checkOutput("async_rst_all_on", 32'(bus.all_on), 32'(e.allOn));
        checkOutput("async_rst_busy", 32'(bus.busy), 32'(e.busy));
        modelEdge(1'b0, 1'b0, 1'b0, 1'b0);
        sbQueue.push_back(modelView());
    endtask

    initial begin : monitor
        expect_t e;
        logic [N-1:0] o;
        forever begin
            @(posedge CLK);
            #1;
            if (sbActive) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = sbQueue.pop_front();
                    o = bus.out;
                    checkOutput("out", 32'(bus.out), 32'(e.out));
                    checkOutput("all_on", 32'(bus.all_on), 32'(e.allOn));
                    checkOutput("busy", 32'(bus.busy), 32'(e.busy));
                    checkOutput("thermometer", 32'((o & (o + 1'b1)) == '0), 32'd1);
`ifdef GLOBAL_CTRL_SEQ_WATCHDOG_EN
                    checkOutput("wdt_fired", 32'(bus.wdt_fired), 32'(e.fired));
`endif
                end
            end
        end
    end

    initial begin : driver
        expect_t e;
        bit st, sp, ka, rs;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
`ifdef GLOBAL_CTRL_SEQ_WATCHDOG_EN
        bus.keepalive = 1'b0;
`endif
        #1;
        rstN = 1'b0;
        modelReset();
        #1;
        e = modelView();
        checkOutput("reset_out", 32'(bus.out), 32'(e.out));
        checkOutput("reset_busy", 32'(bus.busy), 32'(e.busy));
        checkOutput("reset_all_on", 32'(bus.all_on), 32'(e.allOn));

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles(5);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        idleCycles(55);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        idleCycles(55);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 100 && mLines < 2; i++) idleCycles(1);
        idleCycles(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        idleCycles(25);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        idleCycles(5);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 100 && mLines < 3; i++) idleCycles(1);
        idleCycles(4);
        asyncResetCheck();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idleCycles(5);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        idleCycles(70);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 150; i++) applyStimulus(1'b0, 1'b0, (i % 5) == 0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        idleCycles(70);

        for (int i = 0; i < 2500; i++) begin
            st = ($urandom_range(0, 999) < 30);
            sp = ($urandom_range(0, 999) < 12);
            ka = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 999) >= 2);
            applyStimulus(st, sp, ka, rs);
        end
        idleCycles(3);

        @(posedge CLK);
        #2;
        sbActive = 1'b0;
        checkOutput("sb_drain", 32'(sbQueue.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
